// File: rtl/envgen_pkg.sv
// envgen_pkg
// Shared definitions for the multi-voice ADSR envelope generator:
//   env_state_t   - per-voice envelope state encoding
//   attack_rate() - strobes per attack step for a 4-bit rate nibble
//   dr_rate()     - strobes per decay/release step for a 4-bit rate nibble
//   voice-count, envelope-width and rate-counter width limits
package envgen_pkg;

  localparam int MIN_VOICES = 1;
  localparam int MAX_VOICES = 16;
  localparam int MIN_ENV_W  = 8;
  localparam int MAX_ENV_W  = 16;
  localparam int RATE_W     = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  function automatic logic [RATE_W-1:0] attack_rate(input logic [3:0] nibble);
    logic [RATE_W-1:0] r;
    case (nibble)
      4'd0:    r = 13'd1;
      4'd1:    r = 13'd2;
      4'd2:    r = 13'd3;
      4'd3:    r = 13'd4;
      4'd4:    r = 13'd7;
      4'd5:    r = 13'd10;
      4'd6:    r = 13'd13;
      4'd7:    r = 13'd15;
      4'd8:    r = 13'd19;
      4'd9:    r = 13'd47;
      4'd10:   r = 13'd94;
      4'd11:   r = 13'd150;
      4'd12:   r = 13'd188;
      4'd13:   r = 13'd562;
      4'd14:   r = 13'd938;
      default: r = 13'd1500;
    endcase
    return r;
  endfunction

  function automatic logic [RATE_W-1:0] dr_rate(input logic [3:0] nibble);
    logic [RATE_W-1:0] r;
    case (nibble)
      4'd0:    r = 13'd1;
      4'd1:    r = 13'd4;
      4'd2:    r = 13'd9;
      4'd3:    r = 13'd14;
      4'd4:    r = 13'd21;
      4'd5:    r = 13'd32;
      4'd6:    r = 13'd38;
      4'd7:    r = 13'd45;
      4'd8:    r = 13'd56;
      4'd9:    r = 13'd141;
      4'd10:   r = 13'd281;
      4'd11:   r = 13'd450;
      4'd12:   r = 13'd562;
      4'd13:   r = 13'd1688;
      4'd14:   r = 13'd2812;
      default: r = 13'd4500;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/envgen_multi_step.sv
// envgen_step
// Purely combinational next-state function for one envelope voice. The top
// level presents the stored state of the voice owning the current slot and
// writes the results back at the end of that slot.
// Optional feature macro: ENVGEN_EXP_DECAY_EN (exponential-like decay/release).
// Ports:
//   state_i, env_i, rate_cnt_i  current stored voice state
//   gate_i, gate_prev_i         live gate and gate seen in the previous slot
//   attack_i .. release_i       rate / level nibbles for this voice
//   state_o, env_o, rate_cnt_o  next stored voice state
module envgen_step
  import envgen_pkg::*;
#(
  parameter int ENV_W        = 8,
  parameter bit RETRIG_RESET = 1'b0
) (
  input  env_state_t        state_i,
  input  logic [ENV_W-1:0]  env_i,
  input  logic [RATE_W-1:0] rate_cnt_i,
  input  logic              gate_i,
  input  logic              gate_prev_i,
  input  logic [3:0]        attack_i,
  input  logic [3:0]        decay_i,
  input  logic [3:0]        sustain_i,
  input  logic [3:0]        release_i,
  output env_state_t        state_o,
  output logic [ENV_W-1:0]  env_o,
  output logic [RATE_W-1:0] rate_cnt_o
);

  localparam logic [ENV_W-1:0] MAX  = '1;
  // Step scales with width so a full-scale sweep takes the same strobe count.
  localparam logic [ENV_W-1:0] STEP = ENV_W'(1 << (ENV_W - 8));

  logic [ENV_W-1:0]  sus;
  logic [ENV_W-1:0]  dec;
  logic [ENV_W:0]    att_sum;
  logic [RATE_W-1:0] rate;
  logic [RATE_W-1:0] cnt_next;
  logic              tick;
  logic              rise;
  logic              fall;

  assign sus  = {(ENV_W/4){sustain_i}};
  assign rise = gate_i & ~gate_prev_i;
  assign fall = ~gate_i & gate_prev_i;

  always_comb begin
    rate = 13'd1;
    case (state_i)
      ST_ATTACK:  rate = attack_rate(attack_i);
      ST_DECAY:   rate = dr_rate(decay_i);
      ST_RELEASE: rate = dr_rate(release_i);
      default:    rate = 13'd1;
    endcase
  end

  assign tick     = (rate_cnt_i >= (rate - 13'd1));
  assign cnt_next = tick ? '0 : (rate_cnt_i + 13'd1);
  assign att_sum  = {1'b0, env_i} + {1'b0, STEP};

`ifdef ENVGEN_EXP_DECAY_EN
  logic [ENV_W-1:0] env_shr;
  assign env_shr = env_i >> 5;
  assign dec     = (env_shr > STEP) ? env_shr : STEP;
`else
  assign dec = STEP;
`endif

  always_comb begin
    state_o    = state_i;
    env_o      = env_i;
    rate_cnt_o = rate_cnt_i;
    if (rise || ((state_i == ST_IDLE) && gate_i)) begin
      state_o    = ST_ATTACK;
      rate_cnt_o = '0;
      if (RETRIG_RESET) env_o = '0;
    end else if (fall) begin
      state_o    = ST_RELEASE;
      rate_cnt_o = '0;
    end else begin
      case (state_i)
        ST_IDLE: env_o = '0;
        ST_ATTACK: begin
          rate_cnt_o = cnt_next;
          if (tick) begin
            if (env_i == MAX) state_o = ST_DECAY;
            else              env_o   = att_sum[ENV_W] ? MAX : att_sum[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          // Also catches sustain being raised above the current level.
          if (env_i <= sus) begin
            state_o    = ST_SUSTAIN;
            env_o      = sus;
            rate_cnt_o = '0;
          end else begin
            rate_cnt_o = cnt_next;
            if (tick) env_o = ((env_i - sus) <= dec) ? sus : (env_i - dec);
          end
        end
        ST_SUSTAIN: env_o = sus;
        ST_RELEASE: begin
          if (env_i == '0) begin
            state_o    = ST_IDLE;
            rate_cnt_o = '0;
          end else begin
            rate_cnt_o = cnt_next;
            if (tick) env_o = (env_i <= dec) ? '0 : (env_i - dec);
          end
        end
        default: state_o = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/envgen_multi.sv
// envgen_multi
// Time-multiplexed ADSR envelope generator. Each accepted sample_strobe starts
// a sweep that updates one voice per clock through a single shared
// envgen_step instance.
// Optional feature macro: ENVGEN_EXP_DECAY_EN (passed through to envgen_step).
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   sample_strobe       starts a sweep (ignored while busy)
//   gate                per-voice gate, bit v = voice v
//   attack, decay, sustain, release_rate  per-voice nibbles, [4v+3:4v]
//   env_out             per-voice envelope, [ENV_W*v +: ENV_W]
//   env_idle            per-voice IDLE flag
//   busy                sweep in progress
//   sweep_done          one-cycle pulse after the last voice is written
module envgen_multi
  import envgen_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int ENV_W        = 8,
  parameter bit RETRIG_RESET = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_strobe,
  input  logic [NUM_VOICES-1:0]       gate,
  input  logic [4*NUM_VOICES-1:0]     attack,
  input  logic [4*NUM_VOICES-1:0]     decay,
  input  logic [4*NUM_VOICES-1:0]     sustain,
  input  logic [4*NUM_VOICES-1:0]     release_rate,
  output logic [ENV_W*NUM_VOICES-1:0] env_out,
  output logic [NUM_VOICES-1:0]       env_idle,
  output logic                        busy,
  output logic                        sweep_done
);

  localparam int                SLOT_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

  env_state_t            state_q    [NUM_VOICES];
  logic [ENV_W-1:0]      env_q      [NUM_VOICES];
  logic [RATE_W-1:0]     rate_cnt_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_prev_q;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  int                slot_idx;
  env_state_t        nxt_state;
  logic [ENV_W-1:0]  nxt_env;
  logic [RATE_W-1:0] nxt_cnt;

  assign slot_idx = int'(slot_q);

  always_comb begin
    busy_d = busy_q;
    slot_d = slot_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (sample_strobe) begin
        busy_d = 1'b1;
        slot_d = '0;
      end
    end else if (slot_q == LAST_SLOT) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      slot_d = '0;
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      slot_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      slot_q <= slot_d;
    end
  end

  envgen_step #(
    .ENV_W        (ENV_W),
    .RETRIG_RESET (RETRIG_RESET)
  ) u_step (
    .state_i     (state_q[slot_q]),
    .env_i       (env_q[slot_q]),
    .rate_cnt_i  (rate_cnt_q[slot_q]),
    .gate_i      (gate[slot_q]),
    .gate_prev_i (gate_prev_q[slot_q]),
    .attack_i    (attack[4*slot_idx +: 4]),
    .decay_i     (decay[4*slot_idx +: 4]),
    .sustain_i   (sustain[4*slot_idx +: 4]),
    .release_i   (release_rate[4*slot_idx +: 4]),
    .state_o     (nxt_state),
    .env_o       (nxt_env),
    .rate_cnt_o  (nxt_cnt)
  );

  // Only the voice owning the current slot is written; busy_q marks a live slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v]    <= ST_IDLE;
        env_q[v]      <= '0;
        rate_cnt_q[v] <= '0;
      end
      gate_prev_q <= '0;
    end else if (busy_q) begin
      state_q[slot_q]     <= nxt_state;
      env_q[slot_q]       <= nxt_env;
      rate_cnt_q[slot_q]  <= nxt_cnt;
      gate_prev_q[slot_q] <= gate[slot_q];
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign env_out[ENV_W*v +: ENV_W] = env_q[v];
    assign env_idle[v]               = (state_q[v] == ST_IDLE);
  end

  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_envgen_multi.sv
module tb_envgen_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_strobe;
  logic [3:0]  gate;
  logic [15:0] attack, decay, sustain, release_rate;
  logic [31:0] env_out;
  logic [3:0]  env_idle;
  logic        busy, sweep_done;

  logic        gate12;
  logic [11:0] env12;
  logic [0:0]  idle12;
  logic        busy12, done12;

  always #5 clk = ~clk;

  envgen_multi #(.NUM_VOICES(4), .ENV_W(8), .RETRIG_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .gate(gate),
    .attack(attack), .decay(decay), .sustain(sustain), .release_rate(release_rate),
    .env_out(env_out), .env_idle(env_idle), .busy(busy), .sweep_done(sweep_done)
  );

  envgen_multi #(.NUM_VOICES(1), .ENV_W(12), .RETRIG_RESET(1'b1)) dut12 (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .gate(gate12),
    .attack(4'h0), .decay(4'h0), .sustain(4'hF), .release_rate(4'h1),
    .env_out(env12), .env_idle(idle12), .busy(busy12), .sweep_done(done12)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model of the 8-bit, 4-voice, resume-on-retrigger instance.
  int ATK [16] = '{1,2,3,4,7,10,13,15,19,47,94,150,188,562,938,1500};
  int DR  [16] = '{1,4,9,14,21,32,38,45,56,141,281,450,562,1688,2812,4500};
  int m_st  [4];
  int m_env [4];
  int m_cnt [4];
  int m_gp  [4];

  typedef struct packed {
    logic [31:0] env;
    logic [3:0]  idle;
  } exp_t;
  exp_t sb_q[$];

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_st[v] = 0; m_env[v] = 0; m_cnt[v] = 0; m_gp[v] = 0;
    end
  endtask

  task automatic model_voice(input int v);
    int  g, sus, rate, dec;
    bit  tick;
    g    = int'(gate[v]);
    sus  = 17 * int'(sustain[4*v +: 4]);
    case (m_st[v])
      1:       rate = ATK[attack[4*v +: 4]];
      2:       rate = DR[decay[4*v +: 4]];
      4:       rate = DR[release_rate[4*v +: 4]];
      default: rate = 1;
    endcase
    tick = (m_cnt[v] >= rate - 1);
    dec  = 1;
`ifdef ENVGEN_EXP_DECAY_EN
    if ((m_env[v] >> 5) > 1) dec = m_env[v] >> 5;
`endif
    if (g != 0 && (m_gp[v] == 0 || m_st[v] == 0)) begin
      m_st[v] = 1; m_cnt[v] = 0;
    end else if (g == 0 && m_gp[v] != 0) begin
      m_st[v] = 4; m_cnt[v] = 0;
    end else begin
      case (m_st[v])
        0: m_env[v] = 0;
        1: if (tick) begin
             m_cnt[v] = 0;
             if (m_env[v] == 255) m_st[v] = 2;
             else m_env[v] = (m_env[v] + 1 > 255) ? 255 : m_env[v] + 1;
           end else m_cnt[v]++;
        2: if (m_env[v] <= sus) begin
             m_st[v] = 3; m_env[v] = sus; m_cnt[v] = 0;
           end else if (tick) begin
             m_cnt[v] = 0;
             m_env[v] = (m_env[v] - dec < sus) ? sus : m_env[v] - dec;
           end else m_cnt[v]++;
        3: m_env[v] = sus;
        4: if (m_env[v] == 0) begin
             m_st[v] = 0; m_cnt[v] = 0;
           end else if (tick) begin
             m_cnt[v] = 0;
             m_env[v] = (m_env[v] - dec < 0) ? 0 : m_env[v] - dec;
           end else m_cnt[v]++;
        default: m_st[v] = 0;
      endcase
    end
    m_gp[v] = g;
  endtask

  task automatic model_sweep();
    exp_t e;
    for (int v = 0; v < 4; v++) begin
      model_voice(v);
      e.env[8*v +: 8] = 8'(m_env[v]);
      e.idle[v]       = (m_st[v] == 0);
    end
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    check("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int v = 0; v < 4; v++)
        check($sformatf("env_v%0d", v), 32'(env_out[8*v +: 8]), 32'(e.env[8*v +: 8]));
      check("env_idle", 32'(env_idle), 32'(e.idle));
    end
  endtask

  task automatic do_strobe();
    @(negedge clk);
    sample_strobe = 1'b1;
    model_sweep();
    @(negedge clk);
    sample_strobe = 1'b0;
    for (int i = 0; i < 20 && !sweep_done; i++) @(negedge clk);
    check("sweep_done_seen", 32'(sweep_done), 32'd1);
    if (sweep_done) sb_compare();
  endtask

  int busy_n, done_n;

  initial begin
    rst_n = 1'b0; sample_strobe = 1'b0;
    gate = 4'b0111; gate12 = 1'b1;
    attack       = 16'h2000;
    decay        = 16'h3000;
    sustain      = 16'hA88F;
    release_rate = 16'h2100;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_env_out", env_out, 32'd0);
    check("rst_env_idle", 32'(env_idle), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_env12", 32'(env12), 32'd0);
    check("rst_idle12", 32'(idle12), 32'd1);
    rst_n = 1'b1;

    for (int n = 1; n <= 520; n++) begin
      if (n == 102) gate[2] = 1'b0;
      if (n == 420) sustain[7:4] = 4'hF;
      if (n == 430) gate[3] = 1'b1;
      if (n == 470) gate[3] = 1'b0;
      if (n == 480) gate[3] = 1'b1;
      if (n == 300) gate12 = 1'b0;
      if (n == 310) gate12 = 1'b1;
      do_strobe();
      if (n == 1)   check("v0_attack_entry_env", 32'(env_out[7:0]), 32'd0);
      if (n == 1)   check("v0_attack_entry_idle", 32'(env_idle[0]), 32'd0);
      if (n == 101) check("v2_env_at_101", 32'(env_out[23:16]), 32'd100);
      if (n == 256) check("v0_peak_256", 32'(env_out[7:0]), 32'd255);
      if (n == 258) check("v1_decay_started", 32'(env_out[15:8]), 32'd254);
      if (n == 400) check("v1_sustain_136", 32'(env_out[15:8]), 32'd136);
      if (n == 420) check("v1_sustain_raised", 32'(env_out[15:8]), 32'd255);
`ifndef ENVGEN_EXP_DECAY_EN
      if (n == 501) check("v2_release_501", 32'(env_out[23:16]), 32'd1);
      if (n == 502) check("v2_release_zero", 32'(env_out[23:16]), 32'd0);
      if (n == 502) check("v2_not_idle_yet", 32'(env_idle[2]), 32'd0);
      if (n == 503) check("v2_idle", 32'(env_idle[2]), 32'd1);
      if (n == 304) check("e12_release_step", 32'(env12), 32'd4079);
`else
      if (n == 520) check("v2_idle_exp", 32'(env_idle[2]), 32'd1);
      if (n == 304) check("e12_release_step_exp", 32'(env12), 32'd3968);
`endif
      if (n == 100) check("e12_ramp_100", 32'(env12), 32'd1584);
      if (n == 257) check("e12_peak", 32'(env12), 32'd4095);
      if (n == 299) check("e12_no_wrap", 32'(env12), 32'd4095);
      if (n == 310) check("e12_retrig_zero", 32'(env12), 32'd0);
      if (n == 310) check("e12_retrig_active", 32'(idle12), 32'd0);
      if (n == 311) check("e12_retrig_attack", 32'(env12), 32'd16);
    end

    // Second strobe at E2 of a sweep must be ignored.
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        busy_n += int'(busy);
        if (sweep_done) begin
          done_n++;
          sb_compare();
        end
      end
      sample_strobe = (i == 0 || i == 2);
      if (i == 0) model_sweep();
    end
    check("busy_span", 32'(busy_n), 32'd4);
    check("done_pulses", 32'(done_n), 32'd1);

    // Reset at E2 aborts the sweep with no sweep_done.
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) done_n += int'(sweep_done);
      if (i == 3) begin
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_env_out", env_out, 32'd0);
        check("mid_rst_idle", 32'(env_idle), 32'hF);
        check("mid_rst_env12", 32'(env12), 32'd0);
      end
      sample_strobe = (i == 0);
      rst_n = (i != 2);
      if (i == 2) begin
        model_reset();
        sb_q.delete();
      end
    end
    check("mid_rst_no_done", 32'(done_n), 32'd0);

    repeat (3) do_strobe();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
